// File: rtl/arb_pkg.sv
// arb_pkg: shared types and constants for the memory port arbiter.
package arb_pkg;
   typedef enum logic {IDLE, WAIT_RSP} arb_state_e;
   typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_LS = 2'd2} arb_owner_e;
   localparam int BE_W  = 4;
   localparam int CNT_W = 4;
endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: saturating data-grant counter with clear; o_hit flags fetch starvation.
module arb_starve_ctr
   import arb_pkg::*;
#(
   parameter int MAX = 4
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_hit
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = i_clr ? '0 : (i_inc && cnt_q != CNT_W'(MAX)) ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   assign o_hit = cnt_q == CNT_W'(MAX);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, data first, one txn outstanding.
// ARB_STARVE_GUARD_EN compiles in the fetch starvation guard.
module mem_port_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_if_req,
   input  logic [ADDR_W-1:0] i_if_addr,
   input  logic              i_if_flush,
   output logic              o_if_gnt,
   output logic              o_if_rvalid,
   output logic [DATA_W-1:0] o_if_rdata,
   input  logic              i_ls_req,
   input  logic              i_ls_we,
   input  logic [ADDR_W-1:0] i_ls_addr,
   input  logic [DATA_W-1:0] i_ls_wdata,
   input  logic [BE_W-1:0]   i_ls_be,
   output logic              o_ls_gnt,
   output logic              o_ls_rvalid,
   output logic [DATA_W-1:0] o_ls_rdata,
   output logic              o_mem_req,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic [BE_W-1:0]   o_mem_be,
   input  logic              i_mem_gnt,
   input  logic              i_mem_rvalid,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_busy,
   output logic [1:0]        o_owner
);
   arb_state_e state_q, state_d;
   arb_owner_e owner_q, owner_d;
   logic       drop_q, drop_d;
   logic       starve_hit, arb_ok, pick_if, pick_ls, mem_req, gnt, rsp;

`ifdef ARB_STARVE_GUARD_EN
   arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clr   (~i_if_req | o_if_gnt),
      .i_inc   (o_ls_gnt & ~i_if_flush),
      .o_hit   (starve_hit)
   );
`else
   assign starve_hit = 1'b0;
`endif

   // Reset gates every combinational path so all outputs read 0 while it is held.
   assign arb_ok  = ~i_reset & ((state_q == IDLE) | i_mem_rvalid);
   assign pick_if = i_if_req & ~i_if_flush & (~i_ls_req | starve_hit);
   assign pick_ls = i_ls_req & ~pick_if;
   assign mem_req = arb_ok & (pick_if | pick_ls);
   assign gnt     = mem_req & i_mem_gnt;
   assign rsp     = ~i_reset & (state_q == WAIT_RSP) & i_mem_rvalid;

   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) begin
         state_q <= IDLE;
         owner_q <= OWN_NONE;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         drop_q  <= drop_d;
      end

   always_comb begin
      state_d = gnt ? WAIT_RSP : rsp ? IDLE : state_q;
      owner_d = gnt ? (pick_if ? OWN_IF : OWN_LS) : rsp ? OWN_NONE : owner_q;
      drop_d  = (gnt | rsp) ? 1'b0 : drop_q | ((state_q == WAIT_RSP) & (owner_q == OWN_IF) & i_if_flush);
   end

   always_comb begin
      o_mem_req   = mem_req;
      o_mem_we    = mem_req & pick_ls & i_ls_we;
      o_mem_addr  = !mem_req ? '0 : pick_if ? i_if_addr : i_ls_addr;
      o_mem_wdata = (mem_req & pick_ls) ? i_ls_wdata : '0;
      o_mem_be    = !mem_req ? '0 : pick_if ? '1 : i_ls_be;
      o_if_gnt    = gnt & pick_if;
      o_ls_gnt    = gnt & pick_ls;
      o_if_rvalid = rsp & (owner_q == OWN_IF) & ~drop_q;
      o_ls_rvalid = rsp & (owner_q == OWN_LS);
      o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
      o_ls_rdata  = o_ls_rvalid ? i_mem_rdata : '0;
      o_busy      = state_q == WAIT_RSP;
      o_owner     = owner_q;
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-queue model.
module tb_mem_port_arbiter;
   localparam int SM = 4;
`ifdef ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic        clk = 1'b0, i_reset;
   logic        i_if_req, i_if_flush, i_ls_req, i_ls_we, i_mem_gnt, i_mem_rvalid;
   logic [31:0] i_if_addr, i_ls_addr, i_ls_wdata, i_mem_rdata;
   logic [3:0]  i_ls_be;
   logic        o_if_gnt, o_if_rvalid, o_ls_gnt, o_ls_rvalid, o_mem_req, o_mem_we, o_busy;
   logic [31:0] o_if_rdata, o_ls_rdata, o_mem_addr, o_mem_wdata;
   logic [3:0]  o_mem_be;
   logic [1:0]  o_owner;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM)) dut (
      .i_clk(clk), .i_reset(i_reset),
      .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_if_flush(i_if_flush),
      .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
      .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_addr(i_ls_addr), .i_ls_wdata(i_ls_wdata),
      .i_ls_be(i_ls_be), .o_ls_gnt(o_ls_gnt), .o_ls_rvalid(o_ls_rvalid), .o_ls_rdata(o_ls_rdata),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be), .i_mem_gnt(i_mem_gnt),
      .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
      .o_busy(o_busy), .o_owner(o_owner)
   );

   typedef struct {int owner; logic [31:0] addr; bit drop;} txn_t;
   txn_t q[$];
   int   sc, n_chk, n_fail;
   int   e_win;
   logic e_mem_req, e_if_gnt, e_ls_gnt, e_if_rv, e_ls_rv, e_busy;
   logic [31:0] e_if_rd, e_ls_rd, e_addr;
   logic [1:0]  e_owner;

   function automatic logic [31:0] memval(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   // Expected outputs this cycle from the outstanding-transaction queue and current inputs.
   task automatic eval();
      bit busy = q.size() != 0;
      bit can  = !busy || i_mem_rvalid;
      bit rsp  = busy && i_mem_rvalid;
      e_win = 0;
      if (i_if_req && !i_if_flush && (!i_ls_req || (GUARD && sc >= SM))) e_win = 1;
      else if (i_ls_req) e_win = 2;
      if (!can) e_win = 0;
      e_mem_req = e_win != 0;
      e_addr    = e_win == 1 ? i_if_addr : i_ls_addr;
      e_if_gnt  = e_win == 1 && i_mem_gnt;
      e_ls_gnt  = e_win == 2 && i_mem_gnt;
      e_if_rv   = rsp && q[0].owner == 1 && !q[0].drop;
      e_ls_rv   = rsp && q[0].owner == 2;
      e_if_rd   = e_if_rv ? i_mem_rdata : 32'h0;
      e_ls_rd   = e_ls_rv ? i_mem_rdata : 32'h0;
      e_busy    = busy;
      e_owner   = busy ? 2'(q[0].owner) : 2'd0;
   endtask

   task automatic commit();
      if (q.size() != 0 && i_mem_rvalid) void'(q.pop_front());
      else if (q.size() != 0 && i_if_flush && q[0].owner == 1) begin
         txn_t t = q[0];
         t.drop = 1'b1;
         q[0] = t;
      end
      if (e_if_gnt || e_ls_gnt) q.push_back('{e_win, e_addr, 1'b0});
      if (!i_if_req || e_if_gnt) sc = 0;
      else if (e_ls_gnt && !i_if_flush && sc < SM) sc++;
   endtask

   task automatic step_begin();
      @(negedge clk);
      eval();
   endtask

   task automatic step_end();
      commit();
      @(posedge clk);
      #1;
   endtask

   task automatic mem_rsp(input bit v);
      i_mem_rvalid = v;
      i_mem_rdata  = (v && q.size() != 0) ? memval(q[0].addr) : 32'h0;
   endtask

   task automatic idle_inputs();
      i_if_req = 0; i_if_flush = 0; i_ls_req = 0; i_ls_we = 0;
      i_if_addr = 0; i_ls_addr = 0; i_ls_wdata = 0; i_ls_be = 0;
      i_mem_gnt = 1; i_mem_rvalid = 0; i_mem_rdata = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      i_reset = 1; i_if_req = 1; i_ls_req = 1; i_ls_addr = 32'h55; i_mem_rvalid = 1;
      #2;
      n_chk++; if (o_mem_req !== 1'b0 || o_ls_gnt !== 1'b0 || o_if_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_req: req/lsg/ifg=%b%b%b want 000", o_mem_req, o_ls_gnt, o_if_gnt); end
      n_chk++; if (o_mem_addr !== 32'h0 || o_busy !== 1'b0 || o_owner !== 2'd0) begin n_fail++; $display("FAIL reset_state: addr=%h busy=%b owner=%0d want 0", o_mem_addr, o_busy, o_owner); end
      @(posedge clk); #1;
      i_reset = 0; idle_inputs();
      q.delete(); sc = 0;
   endtask

   task automatic test_fetch_seq();
      for (int k = 0; k < 4; k++) begin
         i_if_req = k < 3; i_if_addr = 32'(4 * k); mem_rsp(k > 0);
         step_begin();
         if (k < 3) begin
            n_chk++; if (o_if_gnt !== 1'b1 || o_mem_addr !== 32'(4 * k)) begin n_fail++; $display("FAIL fetch_gnt[%0d]: gnt=%b addr=%h want 1 %h", k, o_if_gnt, o_mem_addr, 4 * k); end
         end
         if (k > 0) begin
            n_chk++; if (o_if_rvalid !== 1'b1 || o_if_rdata !== memval(32'(4 * (k - 1)))) begin n_fail++; $display("FAIL fetch_data[%0d]: rv=%b data=%h want 1 %h", k, o_if_rvalid, o_if_rdata, memval(32'(4 * (k - 1)))); end
         end
         n_chk++; if (o_ls_rvalid !== 1'b0) begin n_fail++; $display("FAIL fetch_ls_rv[%0d]: got %b want 0", k, o_ls_rvalid); end
         step_end();
      end
      idle_inputs();
   endtask

   task automatic test_priority();
      i_if_req = 1; i_if_addr = 32'h100; i_ls_req = 1; i_ls_addr = 32'h1000;
      step_begin();
      n_chk++; if (o_ls_gnt !== 1'b1 || o_if_gnt !== 1'b0 || o_mem_addr !== 32'h1000) begin n_fail++; $display("FAIL prio_gnt: ls=%b if=%b addr=%h want 1 0 00001000", o_ls_gnt, o_if_gnt, o_mem_addr); end
      step_end();
      i_ls_req = 0; mem_rsp(1);
      step_begin();
      n_chk++; if (o_ls_rvalid !== 1'b1 || o_ls_rdata !== memval(32'h1000)) begin n_fail++; $display("FAIL prio_ldata: rv=%b data=%h want 1 %h", o_ls_rvalid, o_ls_rdata, memval(32'h1000)); end
      n_chk++; if (o_if_gnt !== 1'b1 || o_mem_addr !== 32'h100) begin n_fail++; $display("FAIL prio_b2b_fetch: gnt=%b addr=%h want 1 00000100", o_if_gnt, o_mem_addr); end
      step_end();
      i_if_req = 0; mem_rsp(1);
      step_begin();
      n_chk++; if (o_if_rvalid !== 1'b1 || o_if_rdata !== memval(32'h100)) begin n_fail++; $display("FAIL prio_fdata: rv=%b data=%h want 1 %h", o_if_rvalid, o_if_rdata, memval(32'h100)); end
      step_end();
      mem_rsp(0);
      step_begin();
      n_chk++; if (o_busy !== 1'b0 || o_owner !== 2'd0) begin n_fail++; $display("FAIL prio_idle: busy=%b owner=%0d want 0 0", o_busy, o_owner); end
      step_end();
      idle_inputs();
   endtask

   task automatic test_flush();
      i_if_req = 1; i_if_addr = 32'h40;
      step_begin();
      n_chk++; if (o_if_gnt !== 1'b1) begin n_fail++; $display("FAIL flush_gnt: got %b want 1", o_if_gnt); end
      step_end();
      i_if_req = 0; i_if_flush = 1;
      step_begin();
      n_chk++; if (o_owner !== 2'd1 || o_if_rvalid !== 1'b0) begin n_fail++; $display("FAIL flush_owner: owner=%0d rv=%b want 1 0", o_owner, o_if_rvalid); end
      step_end();
      i_if_flush = 0; mem_rsp(1);
      step_begin();
      n_chk++; if (o_if_rvalid !== 1'b0 || o_ls_rvalid !== 1'b0 || o_if_rdata !== 32'h0) begin n_fail++; $display("FAIL flush_drop: ifrv=%b lsrv=%b data=%h want 0 0 0", o_if_rvalid, o_ls_rvalid, o_if_rdata); end
      step_end();
      mem_rsp(0);
      step_begin();
      n_chk++; if (o_owner !== 2'd0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL flush_release: owner=%0d busy=%b want 0 0", o_owner, o_busy); end
      step_end();
      idle_inputs();
   endtask

   task automatic test_store();
      i_ls_req = 1; i_ls_we = 1; i_ls_addr = 32'h2000; i_ls_wdata = 32'hDEADBEEF; i_ls_be = 4'b0011;
      step_begin();
      n_chk++; if (o_ls_gnt !== 1'b1 || o_mem_we !== 1'b1 || o_mem_be !== 4'b0011 || o_mem_wdata !== 32'hDEADBEEF || o_mem_addr !== 32'h2000) begin n_fail++; $display("FAIL store_issue: gnt=%b we=%b be=%b wd=%h addr=%h want 1 1 0011 deadbeef 00002000", o_ls_gnt, o_mem_we, o_mem_be, o_mem_wdata, o_mem_addr); end
      step_end();
      i_ls_req = 0; i_ls_we = 0;
      for (int k = 0; k < 3; k++) begin
         mem_rsp(k == 1);
         step_begin();
         n_chk++; if (o_ls_rvalid !== (k == 1)) begin n_fail++; $display("FAIL store_ack[%0d]: got %b want %b", k, o_ls_rvalid, k == 1); end
         step_end();
      end
      idle_inputs();
   endtask

   task automatic test_starve();
      i_if_req = 1; i_if_addr = 32'h500; i_ls_req = 1; i_ls_addr = 32'h3000;
      for (int k = 0; k < 15; k++) begin
         bit want_if = GUARD && (k % 5 == 4);
         mem_rsp(k > 0);
         step_begin();
         n_chk++; if (o_if_gnt !== want_if || o_ls_gnt !== !want_if) begin n_fail++; $display("FAIL starve[%0d]: if=%b ls=%b want %b %b", k, o_if_gnt, o_ls_gnt, want_if, !want_if); end
         step_end();
      end
      i_if_req = 0; i_ls_req = 0; mem_rsp(1);
      step_begin(); step_end();
      idle_inputs();
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         if (e_if_gnt || !i_if_req) begin i_if_req = 1'($urandom_range(0, 1)); i_if_addr = $urandom & 32'hFFFF_FFFC; end
         if (e_ls_gnt || !i_ls_req) begin
            i_ls_req = 1'($urandom_range(0, 1)); i_ls_we = 1'($urandom_range(0, 1));
            i_ls_addr = $urandom; i_ls_wdata = $urandom; i_ls_be = 4'($urandom);
         end
         i_if_flush = $urandom_range(0, 9) == 0;
         i_mem_gnt = $urandom_range(0, 3) != 0;
         if (q.size() != 0) mem_rsp(1'($urandom_range(0, 1)));
         else begin i_mem_rvalid = $urandom_range(0, 9) == 0; i_mem_rdata = $urandom; end
         step_begin();
         n_chk++; if ({o_mem_req, o_if_gnt, o_ls_gnt} !== {e_mem_req, e_if_gnt, e_ls_gnt}) begin n_fail++; $display("FAIL rnd_gnt[%0d]: req/ifg/lsg=%b%b%b want %b%b%b", k, o_mem_req, o_if_gnt, o_ls_gnt, e_mem_req, e_if_gnt, e_ls_gnt); end
         n_chk++; if ({o_if_rvalid, o_ls_rvalid, o_if_rdata, o_ls_rdata} !== {e_if_rv, e_ls_rv, e_if_rd, e_ls_rd}) begin n_fail++; $display("FAIL rnd_rsp[%0d]: ifrv=%b lsrv=%b ifd=%h lsd=%h want %b %b %h %h", k, o_if_rvalid, o_ls_rvalid, o_if_rdata, o_ls_rdata, e_if_rv, e_ls_rv, e_if_rd, e_ls_rd); end
         n_chk++; if (o_busy !== e_busy || o_owner !== e_owner) begin n_fail++; $display("FAIL rnd_status[%0d]: busy=%b owner=%0d want %b %0d", k, o_busy, o_owner, e_busy, e_owner); end
         if (e_mem_req) begin
            n_chk++; if (o_mem_addr !== e_addr || o_mem_we !== (e_win == 2 && i_ls_we)) begin n_fail++; $display("FAIL rnd_payload[%0d]: addr=%h we=%b want %h %b", k, o_mem_addr, o_mem_we, e_addr, e_win == 2 && i_ls_we); end
         end
         if (e_win == 2) begin
            n_chk++; if (o_mem_wdata !== i_ls_wdata || o_mem_be !== i_ls_be) begin n_fail++; $display("FAIL rnd_ls_payload[%0d]: wd=%h be=%b want %h %b", k, o_mem_wdata, o_mem_be, i_ls_wdata, i_ls_be); end
         end
         step_end();
      end
      idle_inputs();
      for (int k = 0; k < 2; k++) begin
         mem_rsp(q.size() != 0);
         step_begin(); step_end();
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      i_if_req = 1; i_if_addr = 32'h80;
      step_begin();
      n_chk++; if (o_if_gnt !== 1'b1) begin n_fail++; $display("FAIL rmid_gnt: got %b want 1", o_if_gnt); end
      step_end();
      i_reset = 1; i_if_addr = 32'h84; mem_rsp(1);
      #1;
      n_chk++; if ({o_busy, o_owner, o_if_rvalid, o_mem_req, o_if_gnt} !== 6'b0) begin n_fail++; $display("FAIL rmid_async: busy=%b owner=%0d rv=%b req=%b gnt=%b want all 0", o_busy, o_owner, o_if_rvalid, o_mem_req, o_if_gnt); end
      n_chk++; if (o_if_rdata !== 32'h0 || o_mem_addr !== 32'h0) begin n_fail++; $display("FAIL rmid_data: rd=%h addr=%h want 0 0", o_if_rdata, o_mem_addr); end
      @(posedge clk); #1;
      i_reset = 0; q.delete(); sc = 0; mem_rsp(0);
      step_begin();
      n_chk++; if (o_if_gnt !== 1'b1 || o_mem_addr !== 32'h84) begin n_fail++; $display("FAIL rmid_fresh: gnt=%b addr=%h want 1 00000084", o_if_gnt, o_mem_addr); end
      step_end();
      i_if_req = 0; mem_rsp(1);
      step_begin();
      n_chk++; if (o_if_rvalid !== 1'b1 || o_if_rdata !== memval(32'h84)) begin n_fail++; $display("FAIL rmid_data2: rv=%b data=%h want 1 %h", o_if_rvalid, o_if_rdata, memval(32'h84)); end
      step_end();
      idle_inputs();
   endtask

   initial begin
      n_chk = 0; n_fail = 0; sc = 0;
      e_if_gnt = 0; e_ls_gnt = 0;
      test_reset();
      test_fetch_seq();
      test_priority();
      test_flush();
      test_store();
      test_starve();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete within 200000 time units");
      $fatal(1, "timeout");
   end
endmodule
